// File: rtl/vram_sync_if.sv
// vram_sync_if: request/vblank/status signals plus the CPU-facing read port and the
// PPU-facing write port of vram_sync_ctrl. master = controller, slave = environment.
// Ports: i_update_req/i_dirty/i_vblank requests; o_cpu_lock/o_busy/o_done status; o_rd_* / i_rd_data read; o_wr_* write.
interface vram_sync_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic              i_update_req;
  logic [3:0]        i_dirty;
  logic              i_vblank;
  logic              o_cpu_lock;
  logic              o_busy;
  logic              o_done;
  logic              o_rd_en;
  logic [1:0]        o_rd_seg;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic              o_wr_en;
  logic [1:0]        o_wr_seg;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;

  modport master (
    input  i_update_req, i_dirty, i_vblank, i_rd_data,
    output o_cpu_lock, o_busy, o_done,
    output o_rd_en, o_rd_seg, o_rd_addr,
    output o_wr_en, o_wr_seg, o_wr_addr, o_wr_data
  );

  modport slave (
    output i_update_req, i_dirty, i_vblank, i_rd_data,
    input  o_cpu_lock, o_busy, o_done,
    input  o_rd_en, o_rd_seg, o_rd_addr,
    input  o_wr_en, o_wr_seg, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/vram_sync_ctrl.sv
// vram_sync_ctrl: at vblank after a publish request, copies all enabled VRAM segments
// (tile, pattern, palette, sprite) word by word from the CPU-facing read port to the
// PPU-facing write port, holding the CPU off VRAM from request until done.
// Ports: clk, rst (sync, active high), bus (vram_sync_if.master: requests, status, rd/wr ports).
// Optional macro VRAM_SYNC_SKIP_EN: i_dirty selects the copied segments; otherwise all four are copied.
module vram_sync_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 1,
  parameter int SEG0_DEPTH = 2048,
  parameter int SEG1_DEPTH = 4096,
  parameter int SEG2_DEPTH = 32,
  parameter int SEG3_DEPTH = 64
) (
  input logic       clk,
  input logic       rst,
  vram_sync_if.master bus
);

  typedef enum logic [2:0] {IDLE, ARMED, COPY, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              en;
    logic [1:0]        seg;
    logic [ADDR_W-1:0] addr;
  } rd_cmd_t;

  state_t            state;
  logic              pend;
  logic [1:0]        drain_cnt;
  logic              rd_en;
  logic [1:0]        rd_seg;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              lock;
  logic              done;
  rd_cmd_t           pipe [RD_LAT];
  logic [3:0]        act_mask;    // mask of the copy that is armed or running
  logic [3:0]        start_mask;  // mask a vblank accepted this cycle would copy

  function automatic logic [ADDR_W-1:0] seg_last(input logic [1:0] s);
    case (s)
      2'd0:    return ADDR_W'(SEG0_DEPTH - 1);
      2'd1:    return ADDR_W'(SEG1_DEPTH - 1);
      2'd2:    return ADDR_W'(SEG2_DEPTH - 1);
      default: return ADDR_W'(SEG3_DEPTH - 1);
    endcase
  endfunction

  // Lowest enabled segment at or above 'from'; bit 2 set means no segment left.
  function automatic logic [2:0] next_seg(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int s = 3; s >= 0; s--)
      if (m[s] && (3'(s) >= from)) r = 3'(s);
    return r;
  endfunction

`ifdef VRAM_SYNC_SKIP_EN
  logic [3:0] mask;
  logic [3:0] pend_mask;

  always_comb begin
    start_mask = mask;
    if (state == IDLE)
      start_mask = bus.i_dirty;
    else if (bus.i_update_req)
      start_mask = mask | bus.i_dirty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      pend_mask <= '0;
    end else begin
      case (state)
        IDLE:        if (bus.i_update_req) mask <= bus.i_dirty;
        ARMED:       if (bus.i_update_req) mask <= mask | bus.i_dirty;
        COPY, DRAIN: if (bus.i_update_req) pend_mask <= pend_mask | bus.i_dirty;
        DONE: begin
          // A request arriving in DONE joins the pending one for the re-armed copy.
          mask      <= pend_mask | (bus.i_update_req ? bus.i_dirty : 4'b0000);
          pend_mask <= '0;
        end
        default: ;
      endcase
    end
  end

  assign act_mask = mask;
`else
  logic unused_dirty;
  assign unused_dirty = ^bus.i_dirty;
  assign start_mask   = 4'hF;
  assign act_mask     = 4'hF;
`endif

  logic       go;
  logic [2:0] first_seg;
  logic [2:0] adv_seg;
  logic       last_in_seg;

  assign go          = bus.i_vblank && ((state == ARMED) || (state == IDLE && bus.i_update_req));
  assign first_seg   = next_seg(start_mask, 3'd0);
  assign adv_seg     = next_seg(act_mask, {1'b0, rd_seg} + 3'd1);
  assign last_in_seg = (rd_addr == seg_last(rd_seg));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= 1'b0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      rd_seg    <= '0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      lock      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_update_req) begin
            state <= ARMED;
            lock  <= 1'b1;
          end
        end
        ARMED: ;
        COPY: begin
          if (bus.i_update_req) pend <= 1'b1;
          if (!last_in_seg) begin
            rd_addr <= rd_addr + 1'b1;
          end else if (!adv_seg[2]) begin
            rd_seg  <= adv_seg[1:0];
            rd_addr <= '0;
          end else begin
            // Last read issued: wait RD_LAT cycles for its write to leave the pipe.
            state     <= DRAIN;
            rd_en     <= 1'b0;
            rd_seg    <= '0;
            rd_addr   <= '0;
            drain_cnt <= 2'(RD_LAT - 1);
          end
        end
        DRAIN: begin
          if (bus.i_update_req) pend <= 1'b1;
          if (drain_cnt == 2'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          pend <= 1'b0;
          if (pend || bus.i_update_req) begin
            state <= ARMED;
          end else begin
            state <= IDLE;
            lock  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (go) begin
        lock <= 1'b1;
        if (first_seg[2]) begin
          // Nothing to copy: publish completes immediately.
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state   <= COPY;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_seg  <= first_seg[1:0];
          rd_addr <= '0;
        end
      end
    end
  end

  // Read command delayed by RD_LAT so it lines up with the returning read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{en: rd_en, seg: rd_seg, addr: rd_addr};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  rd_cmd_t wr_cmd;
  assign wr_cmd = pipe[RD_LAT-1];

  assign bus.o_cpu_lock = lock;
  assign bus.o_busy     = busy;
  assign bus.o_done     = done;
  assign bus.o_rd_en    = rd_en;
  assign bus.o_rd_seg   = rd_seg;
  assign bus.o_rd_addr  = rd_addr;
  assign bus.o_wr_en    = wr_cmd.en;
  assign bus.o_wr_seg   = wr_cmd.seg;
  assign bus.o_wr_addr  = wr_cmd.addr;
  assign bus.o_wr_data  = wr_cmd.en ? bus.i_rd_data : '0;

endmodule

// File: tb/tb_vram_sync_ctrl.sv
// tb_vram_sync_ctrl: randomized publish scenarios for vram_sync_ctrl checked against a
// segment-list model (expected read/write order, timing, data, lock/busy/done levels).
// Ports: none; instantiates vram_sync_if and vram_sync_ctrl with small segment depths.
`timescale 1ns/1ps
module tb_vram_sync_ctrl;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 3;
  localparam int D0 = 16, D1 = 32, D2 = 4, D3 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_sync_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .SEG0_DEPTH(D0), .SEG1_DEPTH(D1), .SEG2_DEPTH(D2), .SEG3_DEPTH(D3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] salt;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                c;
    logic [1:0]        seg;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];
  bit  lock_at[int];
  bit  busy_at[int];

  function automatic int depth(input int s);
    case (s)
      0:       return D0;
      1:       return D1;
      2:       return D2;
      default: return D3;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [3:0] d);
`ifdef VRAM_SYNC_SKIP_EN
    return d;
`else
    return d | 4'hF;
`endif
  endfunction

  // Memory contents: unique per (segment, address), varied per run by salt.
  function automatic logic [DATA_W-1:0] mem(input logic [1:0] s, input logic [ADDR_W-1:0] a);
    return {salt, 14'd0, s, 3'd0, a};
  endfunction

  // CPU-facing memory with RD_LAT read latency; junk when no read is returning.
  logic [ADDR_W+2:0] hist [0:RD_LAT];
  always @(posedge clk) begin
    #1;
    for (int i = RD_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {bus.o_rd_en, bus.o_rd_seg, bus.o_rd_addr};
    if (hist[RD_LAT][ADDR_W+2] === 1'b1)
      bus.i_rd_data = mem(hist[RD_LAT][ADDR_W+1:ADDR_W], hist[RD_LAT][ADDR_W-1:0]);
    else
      bus.i_rd_data = {$urandom, $urandom};
  end

  always @(negedge clk) begin
    if (bus.o_rd_en) rd_q.push_back('{cyc, bus.o_rd_seg, bus.o_rd_addr, '0});
    if (bus.o_wr_en) wr_q.push_back('{cyc, bus.o_wr_seg, bus.o_wr_addr, bus.o_wr_data});
    if (bus.o_done)  done_q.push_back(cyc);
    lock_at[cyc] = bus.o_cpu_lock;
    busy_at[cyc] = bus.o_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_q.delete(); wr_q.delete(); done_q.delete(); lock_at.delete(); busy_at.delete();
  endtask

  task automatic pulse_req(input logic [3:0] d);
    bus.i_update_req = 1'b1;
    bus.i_dirty      = d;
    step();
    bus.i_update_req = 1'b0;
    bus.i_dirty      = 4'($urandom);
  endtask

  task automatic pulse_vblank(output int t);
    bus.i_vblank = 1'b1;
    t = cyc;
    step();
    bus.i_vblank = 1'b0;
  endtask

  // Checks one publish whose starting vblank was sampled in cycle t.
  task automatic expect_copy(input logic [3:0] d, input int t, input bit vb_at_done,
                             input bit lock_after, input string nm);
    logic [3:0] m;
    int es[$];
    int ea[$];
    int n, tdone, err, first_bad, cnt, got, want;
    m = model_mask(d);
    for (int s = 0; s < 4; s++)
      if (m[s]) for (int a = 0; a < depth(s); a++) begin es.push_back(s); ea.push_back(a); end
    n = es.size();
    tdone = (n == 0) ? t + 1 : t + n + RD_LAT + 1;
    while (cyc < tdone + 2) begin
      if (vb_at_done && cyc == tdone) bus.i_vblank = 1'b1;
      if (vb_at_done && cyc == tdone + 1) bus.i_vblank = 1'b0;
      step();
    end
    if (vb_at_done) bus.i_vblank = 1'b0;

    total++;
    if (rd_q.size() != n) begin
      bad++; $display("FAIL %s rd_count got=%0d want=%0d", nm, rd_q.size(), n);
    end
    err = 0; first_bad = -1;
    for (int i = 0; i < rd_q.size() && i < n; i++)
      if (rd_q[i].c != t + 1 + i || rd_q[i].seg != 2'(es[i]) || rd_q[i].addr != ADDR_W'(ea[i])) begin
        err++; if (first_bad < 0) first_bad = i;
      end
    total++;
    if (err != 0) begin
      bad++; $display("FAIL %s rd_order bad_entries=%0d want=0 first_index=%0d", nm, err, first_bad);
    end

    total++;
    if (wr_q.size() != n) begin
      bad++; $display("FAIL %s wr_count got=%0d want=%0d", nm, wr_q.size(), n);
    end
    err = 0; first_bad = -1;
    for (int i = 0; i < wr_q.size() && i < n; i++)
      if (wr_q[i].c != t + 1 + RD_LAT + i || wr_q[i].seg != 2'(es[i]) ||
          wr_q[i].addr != ADDR_W'(ea[i]) || wr_q[i].data !== mem(2'(es[i]), ADDR_W'(ea[i]))) begin
        err++; if (first_bad < 0) first_bad = i;
      end
    total++;
    if (err != 0) begin
      bad++; $display("FAIL %s wr_order_data bad_entries=%0d want=0 first_index=%0d", nm, err, first_bad);
    end

    total++;
    if (done_q.size() != 1) begin
      bad++; $display("FAIL %s done_pulses got=%0d want=1", nm, done_q.size());
    end
    got = (done_q.size() > 0) ? done_q[0] : -1;
    total++;
    if (got != tdone) begin
      bad++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, got, tdone);
    end

    cnt = 0;
    foreach (busy_at[c]) if (busy_at[c]) cnt++;
    want = (n == 0) ? 0 : n + RD_LAT;
    total++;
    if (cnt != want) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", nm, cnt, want);
    end

    cnt = 0;
    for (int c = t + 1; c <= tdone; c++) if (lock_at.exists(c) && !lock_at[c]) cnt++;
    total++;
    if (cnt != 0) begin
      bad++; $display("FAIL %s lock_low_cycles got=%0d want=0", nm, cnt);
    end
    total++;
    if (lock_at[tdone+1] !== lock_after) begin
      bad++; $display("FAIL %s lock_after_done got=%0b want=%0b", nm, lock_at[tdone+1], lock_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_update_req = 1'b1;
    bus.i_vblank     = 1'b1;
    bus.i_dirty      = 4'hF;
    repeat (3) step();
    total++;
    if (bus.o_cpu_lock !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      bad++; $display("FAIL reset_status got=%b%b%b want=000", bus.o_cpu_lock, bus.o_busy, bus.o_done);
    end
    total++;
    if (bus.o_rd_en !== 1'b0 || bus.o_rd_seg !== 2'd0 || bus.o_rd_addr !== '0) begin
      bad++; $display("FAIL reset_rd got=%b/%0d/%0d want=0/0/0", bus.o_rd_en, bus.o_rd_seg, bus.o_rd_addr);
    end
    total++;
    if (bus.o_wr_en !== 1'b0 || bus.o_wr_seg !== 2'd0 || bus.o_wr_addr !== '0 || bus.o_wr_data !== '0) begin
      bad++; $display("FAIL reset_wr got=%b/%0d/%0d/%h want=0/0/0/0", bus.o_wr_en, bus.o_wr_seg,
                      bus.o_wr_addr, bus.o_wr_data);
    end
    bus.i_update_req = 1'b0;
    bus.i_vblank     = 1'b0;
    rst = 1'b0;
    clear_logs();
    repeat (5) step();
    total++;
    if (bus.o_cpu_lock !== 1'b0 || rd_q.size() != 0) begin
      bad++; $display("FAIL post_reset_idle lock=%b rds=%0d want=0/0", bus.o_cpu_lock, rd_q.size());
    end
  endtask

  task automatic test_full_copy(input logic [3:0] d, input string nm);
    int t;
    clear_logs();
    pulse_req(d);
    repeat (9) step();
    total++;
    if (bus.o_cpu_lock !== 1'b1 || bus.o_busy !== 1'b0) begin
      bad++; $display("FAIL %s armed_levels lock/busy got=%b/%b want=1/0", nm, bus.o_cpu_lock, bus.o_busy);
    end
    pulse_vblank(t);
    expect_copy(d, t, 1'b0, 1'b0, nm);
  endtask

  task automatic test_same_cycle(input logic [3:0] d, input string nm);
    int t;
    clear_logs();
    bus.i_update_req = 1'b1;
    bus.i_dirty      = d;
    pulse_vblank(t);
    bus.i_update_req = 1'b0;
    expect_copy(d, t, 1'b0, 1'b0, nm);
  endtask

  task automatic test_armed_or();
    int t;
    logic [3:0] d1, d2;
    d1 = 4'($urandom); d2 = 4'($urandom);
    clear_logs();
    pulse_req(d1);
    repeat (2) step();
    pulse_req(d2);
    repeat (2) step();
    pulse_vblank(t);
    expect_copy(d1 | d2, t, 1'b0, 1'b0, "armed_or");
  endtask

  task automatic test_pending();
    int t, t2, k;
    logic [3:0] d2;
    d2 = 4'b1000;
    k = $urandom_range(2, 20);
    clear_logs();
    pulse_req(4'hF);
    pulse_vblank(t);
    fork
      expect_copy(4'hF, t, 1'b1, 1'b1, "pending_first");
      begin
        repeat (k) step();
        pulse_req(d2);
        repeat (3) step();
        bus.i_vblank = 1'b1;
        step();
        bus.i_vblank = 1'b0;
      end
    join
    clear_logs();
    repeat (4) step();
    total++;
    if (bus.o_cpu_lock !== 1'b1 || bus.o_busy !== 1'b0) begin
      bad++; $display("FAIL pending_armed lock/busy got=%b/%b want=1/0", bus.o_cpu_lock, bus.o_busy);
    end
    pulse_vblank(t2);
    expect_copy(d2, t2, 1'b0, 1'b0, "pending_second");
  endtask

  task automatic test_reset_mid();
    int t;
    bit found;
    clear_logs();
    pulse_req(4'hF);
    pulse_vblank(t);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (bus.o_rd_en === 1'b1 && bus.o_rd_seg == 2'd1 && bus.o_rd_addr == ADDR_W'(5)) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL reset_mid_reach got=timeout want=rd seg1 addr5");
    end
    rst = 1'b1;
    step();
    total++;
    if ({bus.o_cpu_lock, bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en} !== 5'b0 ||
        bus.o_rd_addr !== '0 || bus.o_wr_addr !== '0 || bus.o_wr_data !== '0) begin
      bad++; $display("FAIL reset_mid_outputs lock/busy/done/rd/wr got=%b%b%b%b%b want=00000",
                      bus.o_cpu_lock, bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en);
    end
    rst = 1'b0;
    clear_logs();
    pulse_vblank(t);
    repeat (80) step();
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0 || bus.o_cpu_lock !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet rd/wr/done/lock got=%0d/%0d/%0d/%b want=0/0/0/0",
                      rd_q.size(), wr_q.size(), done_q.size(), bus.o_cpu_lock);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 4'($urandom);
      repeat ($urandom_range(0, 4)) step();
      if ($urandom_range(0, 1) == 0) test_full_copy(d, "rand_armed");
      else test_same_cycle(d, "rand_same");
    end
  endtask

  initial begin
    salt             = $urandom;
    rst              = 1'b1;
    bus.i_update_req = 1'b0;
    bus.i_vblank     = 1'b0;
    bus.i_dirty      = 4'h0;
    bus.i_rd_data    = '0;
    test_reset();
    test_full_copy(4'hF, "full_copy");
    test_same_cycle(4'hF, "same_cycle");
    test_full_copy(4'b0101, "skip_0101");
    test_full_copy(4'b0000, "empty_mask");
    test_armed_or();
    test_pending();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
